// File: rtl/cpu_pkg.sv
// Shared definitions for the four-entry write-back register file.
// Contents: default data width, reset/clear value, clear-engine state
// encoding and the register address type.
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] RESET_VAL = 16'h0000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef logic [1:0] reg_addr_t;

endpackage

// File: rtl/regfile4x16_wb_if.sv
// Write-port and clear-engine bus of the register file.
// Signals:
//   WR_VALID / WR_READY  write handshake
//   WR_ADDR, WR_DATA     target entry and data
//   CLR_REQ              sequential clear request (level)
//   BUSY, DONE           clear status
// Modports: master (upstream stage), slave (register file).
interface regfile4x16_wb_if #(
  parameter int WIDTH = cpu_pkg::WIDTH
);
  logic              WR_VALID;
  logic              WR_READY;
  cpu_pkg::reg_addr_t WR_ADDR;
  logic [WIDTH-1:0]  WR_DATA;
  logic              CLR_REQ;
  logic              BUSY;
  logic              DONE;

  modport master (
    output WR_VALID, WR_ADDR, WR_DATA, CLR_REQ,
    input  WR_READY, BUSY, DONE
  );

  modport slave (
    input  WR_VALID, WR_ADDR, WR_DATA, CLR_REQ,
    output WR_READY, BUSY, DONE
  );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks a 2-bit pointer over entries 0..3,
// one entry per cycle, and reports BUSY / DONE.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clr_req_i       clear request, sampled only in IDLE
//   ready_o         write port may accept (IDLE)
//   busy_o          clear in progress
//   done_o          one-cycle pulse after the last entry is cleared
//   clr_stb_o       one-hot per-entry clear strobe
//
// state | meaning
// IDLE  | writes accepted, waiting for CLR_REQ
// CLEAR | clearing entry ptr each cycle, writes stalled
module regfile_clr_fsm
  import cpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_req_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] clr_stb_o
);

  state_e    state_q, state_d;
  reg_addr_t ptr_q, ptr_d;
  logic      done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    clr_stb_o = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        clr_stb_o[ptr_q] = 1'b1;
        // pointer wraps 3->0 as the engine returns to IDLE
        ptr_d = ptr_q + 2'd1;
        if (ptr_q == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // status decoded from registered state only
  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == CLEAR);
  assign done_o  = done_q;

endmodule

// File: rtl/regfile4x16_wb.sv
// Four-entry write-back register file feeding the 16-bit 4:1 operand mux.
// Ports:
//   CLK, RST_N   clock, async active-low reset
//   wb           write handshake + clear request/status (slave modport)
//   Q0..Q3       entry contents, drive mux D_IN0..D_IN3
// Build option: REGFILE_R0_ZERO_EN hardwires entry 0 to RESET_VAL; writes
// to address 0 still complete the handshake but are dropped.
module regfile4x16_wb #(
  parameter int               WIDTH     = cpu_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = cpu_pkg::RESET_VAL
) (
  input  logic             CLK,
  input  logic             RST_N,
  regfile4x16_wb_if.slave  wb,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3
);

  logic [3:0][WIDTH-1:0] q_q, q_d;
  logic [3:0]            clr_stb;
  logic                  wr_en;

  regfile_clr_fsm u_clr_fsm (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .clr_req_i (wb.CLR_REQ),
    .ready_o   (wb.WR_READY),
    .busy_o    (wb.BUSY),
    .done_o    (wb.DONE),
    .clr_stb_o (clr_stb)
  );

  assign wr_en = wb.WR_VALID && wb.WR_READY;

  // Clear strobes and writes never coincide (READY is low during CLEAR);
  // clear still takes priority so the decode stays unambiguous.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < 4; i++) begin
      if (clr_stb[i]) begin
        q_d[i] = RESET_VAL;
      end else if (wr_en && (wb.WR_ADDR == 2'(i))) begin
        q_d[i] = wb.WR_DATA;
      end
    end
`ifdef REGFILE_R0_ZERO_EN
    q_d[0] = RESET_VAL;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q <= {4{RESET_VAL}};
    end else begin
      q_q <= q_d;
    end
  end

`ifdef REGFILE_R0_ZERO_EN
  assign Q0 = RESET_VAL;
`else
  assign Q0 = q_q[0];
`endif
  assign Q1 = q_q[1];
  assign Q2 = q_q[2];
  assign Q3 = q_q[3];

endmodule

// File: tb/tb_regfile4x16_wb.sv
module tb_regfile4x16_wb;
  import cpu_pkg::*;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] Q0, Q1, Q2, Q3;

  regfile4x16_wb_if bus ();

  regfile4x16_wb dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .wb    (bus),
    .Q0    (Q0),
    .Q1    (Q1),
    .Q2    (Q2),
    .Q3    (Q3)
  );

  always #5 CLK = ~CLK;

  // downstream operand mux
  logic [1:0]  sel;
  logic [15:0] mux_out;
  always_comb begin
    mux_out = Q0;
    case (sel)
      2'd0: mux_out = Q0;
      2'd1: mux_out = Q1;
      2'd2: mux_out = Q2;
      2'd3: mux_out = Q3;
      default: mux_out = Q0;
    endcase
  end

  typedef struct packed {
    logic [3:0][15:0] q;
    logic             rdy;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] m[4];
  logic        m_busy, m_done;
  int          m_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = RESET_VAL;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic push_model();
    exp_t e;
    for (int i = 0; i < 4; i++) e.q[i] = m[i];
    e.rdy  = !m_busy;
    e.busy = m_busy;
    e.done = m_done;
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q0"}, Q0, e.q[0]);
      chk({tag, "_q1"}, Q1, e.q[1]);
      chk({tag, "_q2"}, Q2, e.q[2]);
      chk({tag, "_q3"}, Q3, e.q[3]);
      chk({tag, "_ready"}, {15'd0, bus.WR_READY}, {15'd0, e.rdy});
      chk({tag, "_busy"},  {15'd0, bus.BUSY},     {15'd0, e.busy});
      chk({tag, "_done"},  {15'd0, bus.DONE},     {15'd0, e.done});
    end
  endtask

  // drive one cycle of stimulus, predict the post-edge state, compare #1 after the edge
  task automatic cycle(input string tag, input logic v, input logic [1:0] a,
                       input logic [15:0] d, input logic c);
    bus.WR_VALID = v;
    bus.WR_ADDR  = a;
    bus.WR_DATA  = d;
    bus.CLR_REQ  = c;
    if (m_busy) begin
      m[m_cnt] = RESET_VAL;
      if (m_cnt == 3) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_done = 1'b0;
      end
      m_cnt = (m_cnt + 1) % 4;
    end else begin
      if (v && !(R0_ZERO && a == 2'd0)) m[a] = d;
      m_done = 1'b0;
      if (c) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    push_model();
    @(posedge CLK);
    #1;
    pop_compare(tag);
  endtask

  initial begin
    logic [15:0] exp0;
    RST_N        = 1'b0;
    bus.WR_VALID = 1'b0;
    bus.WR_ADDR  = 2'd0;
    bus.WR_DATA  = 16'h0;
    bus.CLR_REQ  = 1'b0;
    sel          = 2'd0;
    model_reset();

    // 1: reset state
    #2;
    push_model();
    pop_compare("reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cycle("idle", 1'b0, 2'd0, 16'h0, 1'b0);

    // 2: consecutive writes and downstream mux
    cycle("wr0", 1'b1, 2'd0, 16'h0001, 1'b0);
    cycle("wr1", 1'b1, 2'd1, 16'h8000, 1'b0);
    cycle("wr2", 1'b1, 2'd2, 16'h0002, 1'b0);
    cycle("wr3", 1'b1, 2'd3, 16'h4000, 1'b0);
    cycle("wr_idle", 1'b0, 2'd0, 16'h0, 1'b0);
    exp0 = R0_ZERO ? 16'h0000 : 16'h0001;
    sel = 2'd0; #1; chk("mux_sel0", mux_out, exp0);
    sel = 2'd1; #1; chk("mux_sel1", mux_out, 16'h8000);
    sel = 2'd2; #1; chk("mux_sel2", mux_out, 16'h0002);
    sel = 2'd3; #1; chk("mux_sel3", mux_out, 16'h4000);

    // 3: fill with FFFF then pulse clear
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 2'(i), 16'hFFFF, 1'b0);
    cycle("clr_start", 1'b0, 2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("clr_run", 1'b0, 2'd0, 16'h0, 1'b0);
    cycle("clr_after", 1'b0, 2'd0, 16'h0, 1'b0);

    // 4: write held during clear, accepted on first IDLE cycle
    for (int i = 0; i < 4; i++) cycle("fill4", 1'b1, 2'(i), 16'hFFFF, 1'b0);
    cycle("hold_start", 1'b0, 2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("hold_busy", 1'b1, 2'd2, 16'h1234, 1'b0);
    cycle("hold_accept", 1'b1, 2'd2, 16'h1234, 1'b0);
    cycle("hold_idle", 1'b0, 2'd0, 16'h0, 1'b0);
    chk("hold_q2", Q2, 16'h1234);

    // 5: clear request and write on the same edge
    cycle("same_edge", 1'b1, 2'd3, 16'hABCD, 1'b1);
    for (int i = 0; i < 4; i++) cycle("same_clr", 1'b0, 2'd0, 16'h0, 1'b0);
    chk("same_q3_final", Q3, 16'h0000);

    // CLR_REQ held high: ignored while busy, restarts after DONE
    for (int i = 0; i < 7; i++) cycle("clr_held", 1'b0, 2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("clr_drain", 1'b0, 2'd0, 16'h0, 1'b0);

    // 6: write to address 0
    cycle("r0_write", 1'b1, 2'd0, 16'h5555, 1'b0);
    cycle("r0_idle", 1'b0, 2'd0, 16'h0, 1'b0);
    chk("r0_q0", Q0, R0_ZERO ? 16'h0000 : 16'h5555);

    // 1b: asynchronous reset in the middle of a clear
    for (int i = 0; i < 4; i++) cycle("fill_rst", 1'b1, 2'(i), 16'hFFFF, 1'b0);
    cycle("rst_clr", 1'b0, 2'd0, 16'h0, 1'b1);
    cycle("rst_clr1", 1'b0, 2'd0, 16'h0, 1'b0);
    cycle("rst_clr2", 1'b0, 2'd0, 16'h0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    push_model();
    pop_compare("midclr_reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cycle("post_reset", 1'b1, 2'd1, 16'h0F0F, 1'b0);
    cycle("post_idle", 1'b0, 2'd0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
